// File: rtl/kalman_step_sequencer.sv
// -----------------------------------------------------------------------------
// kalman_step_sequencer
//
// Control FSM for the scalar Kalman filter core. Accepts one measurement z
// through a valid/ready handshake, then issues the four filter micro-ops
// (predict, gain, state update, covariance update) to the shared arithmetic
// datapath, waiting for op_done on each, and finally pulses est_valid.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 design enable; low freezes all state
//   meas_valid/ready    measurement handshake, meas_data = z
//   op_valid/op_code    micro-op request (1=PRED 2=GAIN 3=UPDX 4=UPDP, 0 idle)
//   op_arg              z latched for the current step
//   op_done             datapath completion of the current op
//   est_valid           one-cycle pulse when a step completes
//   busy                high in every state except IDLE
//   err                 sticky op timeout flag
//   step_cnt            completed steps, wraps 255 -> 0
//
// Optional feature: define KSEQ_TIMEOUT_EN to build the op watchdog. An op
// that waits TIMEOUT cycles for op_done sets err and aborts to IDLE. Without
// the macro err is constant 0 and ops wait indefinitely.
// -----------------------------------------------------------------------------
module kalman_step_sequencer #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          meas_valid,
    input  logic [DW-1:0] meas_data,
    output logic          meas_ready,
    output logic          op_valid,
    output logic [2:0]    op_code,
    output logic [DW-1:0] op_arg,
    input  logic          op_done,
    output logic          est_valid,
    output logic          busy,
    output logic          err,
    output logic [7:0]    step_cnt
);

    // Op states are encoded with their op_code so the code follows the state.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRED = 3'd1,
        S_GAIN = 3'd2,
        S_UPDX = 3'd3,
        S_UPDP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_reg;
    logic            ready_reg;
    logic            op_valid_reg;
    logic [2:0]      op_code_reg;
    logic [DW-1:0]   op_arg_reg;
    logic            est_valid_reg;
    logic            busy_reg;
    logic [7:0]      step_cnt_reg;

`ifdef KSEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   wait_cnt_reg;
    logic            err_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ready_reg     <= 1'b0;
            op_valid_reg  <= 1'b0;
            op_code_reg   <= 3'd0;
            op_arg_reg    <= '0;
            est_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            step_cnt_reg  <= 8'd0;
`ifdef KSEQ_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else if (ena) begin
            // With ena low nothing advances; a pending est_valid in DONE
            // therefore still fires exactly once after resume.
            est_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (ready_reg && meas_valid) begin
                        op_arg_reg   <= meas_data;
                        state_reg    <= S_PRED;
                        ready_reg    <= 1'b0;
                        op_valid_reg <= 1'b1;
                        op_code_reg  <= 3'd1;
                        busy_reg     <= 1'b1;
`ifdef KSEQ_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                S_PRED, S_GAIN, S_UPDX, S_UPDP: begin
                    if (op_done) begin
                        if (state_reg == S_UPDP) begin
                            state_reg     <= S_DONE;
                            op_valid_reg  <= 1'b0;
                            op_code_reg   <= 3'd0;
                            est_valid_reg <= 1'b1;
                            step_cnt_reg  <= step_cnt_reg + 8'd1;
                        end else begin
                            state_reg   <= state_t'(state_reg + 3'd1);
                            op_code_reg <= state_reg + 3'd1;
                        end
`ifdef KSEQ_TIMEOUT_EN
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
                        // This edge is the TIMEOUT-th stalled cycle: abort,
                        // skipping DONE so neither est_valid nor step_cnt move.
                        err_reg      <= 1'b1;
                        state_reg    <= S_IDLE;
                        op_valid_reg <= 1'b0;
                        op_code_reg  <= 3'd0;
                        busy_reg     <= 1'b0;
                        ready_reg    <= 1'b1;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
`endif
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= S_IDLE;
                    op_valid_reg <= 1'b0;
                    op_code_reg  <= 3'd0;
                    busy_reg     <= 1'b0;
                    ready_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Handshake strobes are masked by ena so a frozen sequencer neither
    // requests ops, accepts measurements nor reports estimates.
    assign meas_ready = ready_reg & ena;
    assign op_valid   = op_valid_reg & ena;
    assign est_valid  = est_valid_reg & ena;
    assign op_code    = op_code_reg;
    assign op_arg     = op_arg_reg;
    assign busy       = busy_reg;
    assign step_cnt   = step_cnt_reg;

`ifdef KSEQ_TIMEOUT_EN
    assign err = err_reg;
`else
    // No watchdog is built; the constant term keeps TIMEOUT referenced.
    assign err = 1'b0 && (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_kalman_step_sequencer.sv
module tb_kalman_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       meas_valid;
    logic [7:0] meas_data;
    logic       meas_ready;
    logic       op_valid;
    logic [2:0] op_code;
    logic [7:0] op_arg;
    logic       op_done;
    logic       est_valid;
    logic       busy;
    logic       err;
    logic [7:0] step_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_steps = 0;

    kalman_step_sequencer #(.DW(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .meas_valid(meas_valid), .meas_data(meas_data), .meas_ready(meas_ready),
        .op_valid(op_valid), .op_code(op_code), .op_arg(op_arg), .op_done(op_done),
        .est_valid(est_valid), .busy(busy), .err(err), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for meas_ready, presents z, and returns just after the
    // accept edge with the sequencer in PRED.
    task automatic accept(input logic [7:0] z);
        for (int i = 0; i < 40 && meas_ready !== 1'b1; i++) tick();
        n_checks++;
        if (meas_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: meas_ready=%b required 1", meas_ready);
        end
        meas_valid = 1'b1;
        meas_data  = z;
        tick();
        meas_valid = 1'b0;
        $display("accept z=0x%02h", z);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; meas_valid = 1'b0; meas_data = 8'h00; op_done = 1'b0;
        #12;
        n_checks++;
        if ({meas_ready, op_valid, op_code, op_arg, est_valid, busy, err, step_cnt} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b oc=%0d arg=%02h ev=%b busy=%b err=%b cnt=%0d required all 0",
                     meas_ready, op_valid, op_code, op_arg, est_valid, busy, err, step_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (meas_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: meas_ready=%b required 1", meas_ready);
        end
        $display("reset released");
    endtask

    task automatic test_basic();
        op_done = 1'b1;
        accept(8'h5A);
        n_checks++;
        if (op_arg !== 8'h5A || busy !== 1'b1 || meas_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: arg=%02h busy=%b rdy=%b required 5a 1 0", op_arg, busy, meas_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (op_valid !== 1'b1 || op_code !== 3'(k)) begin
                n_fail++;
                $display("FAIL basic_op%0d: ov=%b oc=%0d required 1 %0d", k, op_valid, op_code, k);
            end
            tick();
        end
        exp_steps++;
        n_checks++;
        if (est_valid !== 1'b1 || op_valid !== 1'b0 || step_cnt !== 8'(exp_steps) || op_arg !== 8'h5A) begin
            n_fail++;
            $display("FAIL basic_done: ev=%b ov=%b cnt=%0d arg=%02h required 1 0 %0d 5a",
                     est_valid, op_valid, step_cnt, op_arg, exp_steps);
        end
        tick();
        n_checks++;
        if (est_valid !== 1'b0 || meas_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: ev=%b rdy=%b busy=%b required 0 1 0", est_valid, meas_ready, busy);
        end
        $display("step done cnt=%0d", step_cnt);
    endtask

    task automatic test_stall_gain();
        int n = 0;
        int gain_cycles = 0;
        int stall = 3;
        op_done = 1'b1;
        accept(8'h33);
        while (est_valid !== 1'b1 && n < 40) begin
            if (op_code == 3'd2) gain_cycles++;
            if (op_code == 3'd2 && stall > 0) begin
                op_done = 1'b0;
                stall--;
            end else begin
                op_done = 1'b1;
            end
            tick();
            n++;
        end
        op_done = 1'b1;
        exp_steps++;
        n_checks++;
        if (n !== 7 || gain_cycles !== 4) begin
            n_fail++;
            $display("FAIL stall_latency: cycles=%0d gain_cycles=%0d required 7 4", n, gain_cycles);
        end
        n_checks++;
        if (err !== 1'b0 || step_cnt !== 8'(exp_steps)) begin
            n_fail++;
            $display("FAIL stall_status: err=%b cnt=%0d required 0 %0d", err, step_cnt, exp_steps);
        end
        tick();
        $display("stalled step done cnt=%0d", step_cnt);
    endtask

    task automatic test_freeze();
        op_done = 1'b1;
        accept(8'h77);
        tick();
        tick();
        n_checks++;
        if (op_code !== 3'd3 || op_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_pre: oc=%0d ov=%b required 3 1", op_code, op_valid);
        end
        ena = 1'b0;
        #1;
        n_checks++;
        if (op_valid !== 1'b0 || meas_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_mask: ov=%b rdy=%b required 0 0", op_valid, meas_ready);
        end
        tick();
        tick();
        n_checks++;
        if (op_code !== 3'd3 || op_valid !== 1'b0 || busy !== 1'b1 || est_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_hold: oc=%0d ov=%b busy=%b ev=%b required 3 0 1 0", op_code, op_valid, busy, est_valid);
        end
        ena = 1'b1;
        #1;
        n_checks++;
        if (op_valid !== 1'b1 || op_code !== 3'd3) begin
            n_fail++;
            $display("FAIL freeze_resume: ov=%b oc=%0d required 1 3", op_valid, op_code);
        end
        tick();
        tick();
        exp_steps++;
        n_checks++;
        if (est_valid !== 1'b1 || step_cnt !== 8'(exp_steps)) begin
            n_fail++;
            $display("FAIL freeze_done: ev=%b cnt=%0d required 1 %0d", est_valid, step_cnt, exp_steps);
        end
        tick();
        $display("frozen step done cnt=%0d", step_cnt);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int ests = 0;
        int last_acc = -1;
        int bad_gap = 0;
        int bad_arg = 0;
        logic wrapped = 1'b0;
        logic [7:0] prev_cnt;
        logic [7:0] last_z = 8'h00;
        op_done = 1'b1;
        prev_cnt = step_cnt;
        meas_valid = 1'b1;
        for (int cyc = 0; cyc < 2000 && ests < 256; cyc++) begin
            meas_data = 8'(cyc * 7 + 1);
            #1;
            if (meas_ready === 1'b1 && meas_valid === 1'b1) begin
                if (last_acc >= 0 && cyc - last_acc != 6) bad_gap++;
                last_acc = cyc;
                last_z = meas_data;
                accepts++;
                $display("b2b accept %0d z=0x%02h", accepts, meas_data);
            end
            tick();
            if (accepts == 256) meas_valid = 1'b0;
            if (busy === 1'b1 && op_arg !== last_z) bad_arg++;
            if (est_valid === 1'b1) ests++;
            if (prev_cnt == 8'd255 && step_cnt == 8'd0) wrapped = 1'b1;
            prev_cnt = step_cnt;
        end
        meas_valid = 1'b0;
        exp_steps = (exp_steps + 256) % 256;
        n_checks++;
        if (accepts !== 256 || ests !== 256 || bad_gap !== 0) begin
            n_fail++;
            $display("FAIL b2b_rate: accepts=%0d ests=%0d bad_gaps=%0d required 256 256 0", accepts, ests, bad_gap);
        end
        n_checks++;
        if (bad_arg !== 0) begin
            n_fail++;
            $display("FAIL b2b_arg: op_arg mismatches=%0d required 0", bad_arg);
        end
        n_checks++;
        if (step_cnt !== 8'(exp_steps) || wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_wrap: cnt=%0d wrapped=%b required %0d 1", step_cnt, wrapped, exp_steps);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int ests = 0;
        op_done = 1'b1;
        accept(8'hC3);
        tick();
        tick();
        tick();
        n_checks++;
        if (op_code !== 3'd4) begin
            n_fail++;
            $display("FAIL rstmid_pre: oc=%0d required 4", op_code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({meas_ready, op_valid, op_code, op_arg, est_valid, busy, err, step_cnt} !== 24'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: rdy=%b ov=%b oc=%0d arg=%02h ev=%b busy=%b cnt=%0d required all 0",
                     meas_ready, op_valid, op_code, op_arg, est_valid, busy, step_cnt);
        end
        exp_steps = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (est_valid === 1'b1) ests++;
            tick();
        end
        n_checks++;
        if (ests !== 0 || step_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_noest: ests=%0d cnt=%0d required 0 0", ests, step_cnt);
        end
        accept(8'h11);
        for (int i = 0; i < 4; i++) tick();
        exp_steps++;
        n_checks++;
        if (est_valid !== 1'b1 || step_cnt !== 8'(exp_steps) || op_arg !== 8'h11) begin
            n_fail++;
            $display("FAIL rstmid_next: ev=%b cnt=%0d arg=%02h required 1 %0d 11", est_valid, step_cnt, op_arg, exp_steps);
        end
        tick();
        $display("post-reset step done cnt=%0d", step_cnt);
    endtask

    task automatic test_timeout();
        op_done = 1'b0;
        accept(8'h99);
`ifdef KSEQ_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (err !== 1'b0 || op_valid !== 1'b1 || op_code !== 3'd1) begin
            n_fail++;
            $display("FAIL timeout_pre: err=%b ov=%b oc=%0d required 0 1 1", err, op_valid, op_code);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || op_valid !== 1'b0 || est_valid !== 1'b0 || step_cnt !== 8'(exp_steps)) begin
            n_fail++;
            $display("FAIL timeout_abort: err=%b busy=%b ov=%b ev=%b cnt=%0d required 1 0 0 0 %0d",
                     err, busy, op_valid, est_valid, step_cnt, exp_steps);
        end
        op_done = 1'b1;
        accept(8'h42);
        for (int i = 0; i < 4; i++) tick();
        exp_steps++;
        n_checks++;
        if (est_valid !== 1'b1 || step_cnt !== 8'(exp_steps) || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: ev=%b cnt=%0d err=%b required 1 %0d 1", est_valid, step_cnt, err, exp_steps);
        end
`else
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (op_valid !== 1'b1 || op_code !== 3'd1 || err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL notimeout_wait: ov=%b oc=%0d err=%b busy=%b required 1 1 0 1", op_valid, op_code, err, busy);
        end
        op_done = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        exp_steps++;
        n_checks++;
        if (est_valid !== 1'b1 || step_cnt !== 8'(exp_steps)) begin
            n_fail++;
            $display("FAIL notimeout_done: ev=%b cnt=%0d required 1 %0d", est_valid, step_cnt, exp_steps);
        end
`endif
        tick();
        $display("timeout scenario done cnt=%0d err=%b", step_cnt, err);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_gain();
        test_freeze();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
